// File: rtl/sd_spi_master.sv
// SPI mode-0 master for the Z80 SD card port: a CS/config register plus a data
// register that starts one full-duplex MSB-first byte exchange per access.
module sd_spi_master #(
  parameter int unsigned HALF_DIV = 0
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce,
  input  logic       cfg_wr,
  input  logic       cfg_din,
  input  logic       data_wr,
  input  logic       data_rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  output logic       SD_CLK,
  output logic       SD_SI,
  input  logic       SD_SO,
  output logic       SD_CS_N
);

  localparam int unsigned CW = (HALF_DIV > 0) ? $clog2(HALF_DIV + 1) : 1;
  localparam logic [CW-1:0] HALF_MAX = CW'(HALF_DIV);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

  state_t        state, state_n;
  logic [CW-1:0] hcnt, hcnt_n;
  logic [2:0]    bcnt, bcnt_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    rx, rx_n;
  logic [7:0]    dout_n;
  logic          busy_n, sclk_n, si_n, cs_n_n;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      hcnt    <= '0;
      bcnt    <= '0;
      shift   <= '0;
      rx      <= '0;
      dout    <= '1;
      busy    <= 1'b0;
      SD_CLK  <= 1'b0;
      SD_SI   <= 1'b1;
      SD_CS_N <= 1'b1;
    end else begin
      state   <= state_n;
      hcnt    <= hcnt_n;
      bcnt    <= bcnt_n;
      shift   <= shift_n;
      rx      <= rx_n;
      dout    <= dout_n;
      busy    <= busy_n;
      SD_CLK  <= sclk_n;
      SD_SI   <= si_n;
      SD_CS_N <= cs_n_n;
    end
  end

  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    bcnt_n  = bcnt;
    shift_n = shift;
    rx_n    = rx;
    dout_n  = dout;
    busy_n  = busy;
    sclk_n  = SD_CLK;
    si_n    = SD_SI;
    // Chip select is a plain register write; it never interrupts a transfer.
    cs_n_n  = cfg_wr ? cfg_din : SD_CS_N;

    case (state)
      S_IDLE: begin
        if (data_wr || data_rd) begin
          shift_n = data_wr ? din : 8'hFF;
          si_n    = data_wr ? din[7] : 1'b1;
          bcnt_n  = '0;
          hcnt_n  = '0;
          busy_n  = 1'b1;
          state_n = S_LOW;
        end
      end
      S_LOW: begin
        if (ce) begin
          if (hcnt == HALF_MAX) begin
            hcnt_n  = '0;
            sclk_n  = 1'b1;
            rx_n    = {rx[6:0], SD_SO};
            state_n = S_HIGH;
          end else begin
            hcnt_n = hcnt + 1'b1;
          end
        end
      end
      S_HIGH: begin
        if (ce) begin
          if (hcnt == HALF_MAX) begin
            hcnt_n = '0;
            sclk_n = 1'b0;
            if (bcnt != 3'd7) begin
              shift_n = {shift[6:0], 1'b0};
              si_n    = shift[6];
              bcnt_n  = bcnt + 3'd1;
              state_n = S_LOW;
            end else begin
              dout_n  = rx;
              busy_n  = 1'b0;
              si_n    = 1'b1;
              state_n = S_IDLE;
            end
          end else begin
            hcnt_n = hcnt + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
